mbinit_param_exchange: RTL
==========================

# mbinit_param_exchange

Runs the MBINIT.PARAM step of link training. It latches the local capability values (maximum data rate, clock mode, clock phase) from the capability register stage. It then exchanges configuration request and response messages with the link partner over the sideband message interface, and publishes the negotiated parameters with a done or error status to the LTSM MBINIT sequencer.

## Interface
- TIMEOUT_CYCLES, 1000: cycles allowed from leaving IDLE to completion before declaring error.
- CNT_W, 16: timeout counter width; must hold TIMEOUT_CYCLES-1.
- CLK  in  1  clock; all flops rising-edge.
- rst  in  1  asynchronous, active-high reset.
- i_en  in  1  level enable from MBINIT sequencer; deassertion aborts to IDLE.
- i_Max_DataRate  in  3  local max rate code (0=4G,1=8G,2=12G,3=16G,4=24G,5=32G).
- i_Clock_Mode  in  2  local clock mode.
- i_Phase_Clock  in  2  local clock phase.
- o_sb_tx_valid  out  1  sideband message valid.
- o_sb_tx_msg  out  4  message code: 4'h1 = PARAM_REQ, 4'h2 = PARAM_RESP.
- o_sb_tx_data  out  16  payload.
- i_sb_tx_ready  in  1  sideband transmitter accepts the message.
- i_sb_rx_valid  in  1  one-cycle strobe for a received message; no backpressure.
- i_sb_rx_msg  in  4  received code.
- i_sb_rx_data  in  16  received payload.
- o_Final_DataRate  out  3  negotiated rate.
- o_Final_Clock_Mode  out  2  negotiated clock mode.
- o_Final_Phase_Clock  out  2  negotiated phase.
- o_done  out  1  exchange complete; final values valid.
- o_error  out  1  exchange failed.

## Operation
- Payload format, both directions: [2:0] rate, [4:3] clock mode, [6:5] phase, [15:7] zero on TX and ignored on RX.
- States: IDLE, SEND_REQ, WAIT, SEND_RESP, DONE, ERROR.
- IDLE to SEND_REQ when i_en=1. On that edge:
  - latch local rate/mode/phase into L_*;
  - clear the flags req_pending, req_answered, resp_got;
  - clear the timeout counter.
- SEND_REQ: tx_valid=1, msg=PARAM_REQ, data={L_phase,L_mode,L_rate}. On valid&&ready, go to WAIT.
- WAIT, evaluated in priority order:
  - req_pending=1: go to SEND_RESP.
  - resp_got && req_answered: go to DONE.
  - otherwise stay.
- SEND_RESP: msg=PARAM_RESP, data = {R_phase, R_mode, min(L_rate,R_rate)}. On valid&&ready, set req_answered, clear req_pending, return to WAIT.
- RX capture is active in SEND_REQ, WAIT and SEND_RESP; it is ignored in IDLE, DONE and ERROR.
- PARAM_REQ received:
  - store R_rate/R_mode/R_phase and set req_pending.
  - If R_mode!=L_mode or R_phase!=L_phase, go to ERROR next edge.
  - A repeat REQ overwrites the stored values and re-arms req_pending even if already answered.
- PARAM_RESP received:
  - store into o_Final_* and set resp_got.
  - If resp rate > L_rate, or resp mode/phase differ from L_*, go to ERROR.
  - A repeat RESP overwrites.
- Unknown message codes are dropped silently.
- Timeout: the counter increments in SEND_REQ/WAIT/SEND_RESP. An edge with count==TIMEOUT_CYCLES-1 goes to ERROR unless a DONE transition occurs on that same edge (completion wins).
- DONE: o_done=1, o_Final_* held. ERROR: o_error=1.
- Both DONE and ERROR hold until i_en=0.
- i_en=0 in any state goes to IDLE next edge and clears flags, o_Final_*, o_done and o_error. A tx message in flight is withdrawn (tx_valid drops).

## Timing
- Reset values: all outputs 0, state IDLE, all flags and L_*/R_* 0.
- tx_valid/msg are decoded from the state register. Payload is registered and stable while valid=1 and ready=0.
- tx_valid rises 1 cycle after i_en is sampled high.
- An RX strobe sampled at edge N updates flags at edge N. A state reaction (SEND_RESP or DONE) is visible after edge N+1.
- The same-cycle REQ plus RESP strobe cannot occur (single RX bus).
- RX arriving on the same edge as tx handshake completion is captured normally.
- Minimum exchange with ready tied high and the partner answering immediately: o_done is high 5 edges after i_en rises.

## Test plan
- Match case:
  - Stimulus: local rate 2/mode 0/phase 1; partner REQ rate 5/mode 0/phase 1; partner RESP rate 2.
  - Required: TX REQ data 16'h0022 and TX RESP data 16'h0022.
  - Required: o_done=1, o_Final_DataRate=2, Clock_Mode=0, Phase_Clock=1.
- Backpressure: hold i_sb_tx_ready=0 for 10 cycles during SEND_REQ. Required: tx_valid, msg and data stable throughout; a REQ received meanwhile is answered after the REQ is accepted.
- Mismatch: partner REQ with mode 2 against local mode 0. Required: o_error=1, o_done=0, no PARAM_RESP sent.
- Timeout: TIMEOUT_CYCLES=20, partner silent. Required: o_error rises on the 20th edge after leaving IDLE.
- Timeout boundary: completing RESP lands so DONE coincides with count 19. Required: o_done=1, o_error=0.
- Abort and reset: drop i_en in WAIT. Required: IDLE next edge with all outputs 0. Assert rst mid-SEND_RESP. Required: all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mbinit_param_exchange_if.sv
// Sideband message port of the MBINIT.PARAM exchange.
// Master drives the TX message and receives partner messages. Slave is the sideband side.
interface mbinit_param_exchange_if;
  localparam int unsigned MSG_W  = 4;
  localparam int unsigned DATA_W = 16;

  logic              tx_valid;
  logic [MSG_W-1:0]  tx_msg;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;
  logic              rx_valid;
  logic [MSG_W-1:0]  rx_msg;
  logic [DATA_W-1:0] rx_data;

  modport master (
    output tx_valid, tx_msg, tx_data,
    input  tx_ready, rx_valid, rx_msg, rx_data
  );

  modport slave (
    input  tx_valid, tx_msg, tx_data,
    output tx_ready, rx_valid, rx_msg, rx_data
  );
endinterface

// File: rtl/mbinit_param_exchange.sv
// MBINIT.PARAM step: trades configuration request/response with the link partner
// and publishes the negotiated rate, clock mode and phase with a done/error status.
module mbinit_param_exchange #(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       i_en,
  input  logic [2:0] i_Max_DataRate,
  input  logic [1:0] i_Clock_Mode,
  input  logic [1:0] i_Phase_Clock,
  mbinit_param_exchange_if.master sb,
  output logic [2:0] o_Final_DataRate,
  output logic [1:0] o_Final_Clock_Mode,
  output logic [1:0] o_Final_Phase_Clock,
  output logic       o_done,
  output logic       o_error
);

  localparam logic [3:0]       MSG_REQ  = 4'h1;
  localparam logic [3:0]       MSG_RESP = 4'h2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_REQ,
    S_WAIT,
    S_SEND_RESP,
    S_DONE,
    S_ERROR
  } state_t;

  state_t           state;
  logic [2:0]       l_rate, r_rate;
  logic [1:0]       l_mode, l_phase, r_mode, r_phase;
  logic             req_pending, req_answered, resp_got;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      tx_data_q;

  logic       active, hs, rx_req, rx_resp, req_bad, resp_bad, done_cond, timeout;
  logic [2:0] rx_rate, resp_rate;
  logic [1:0] rx_mode, rx_phase;
  logic       unused_rx_hi;

  // Payload fields; upper bits carry nothing on receive.
  assign rx_rate      = sb.rx_data[2:0];
  assign rx_mode      = sb.rx_data[4:3];
  assign rx_phase     = sb.rx_data[6:5];
  assign unused_rx_hi = ^sb.rx_data[15:7];

  assign active    = (state == S_SEND_REQ) || (state == S_WAIT) || (state == S_SEND_RESP);
  assign hs        = sb.tx_valid && sb.tx_ready;
  assign rx_req    = active && sb.rx_valid && (sb.rx_msg == MSG_REQ);
  assign rx_resp   = active && sb.rx_valid && (sb.rx_msg == MSG_RESP);
  assign req_bad   = rx_req && ((rx_mode != l_mode) || (rx_phase != l_phase));
  assign resp_bad  = rx_resp && ((rx_rate > l_rate) || (rx_mode != l_mode) ||
                                 (rx_phase != l_phase));
  assign done_cond = (state == S_WAIT) && !req_pending && resp_got && req_answered;
  assign timeout   = (cnt == CNT_LAST);
  assign resp_rate = (l_rate < r_rate) ? l_rate : r_rate;

  // TX valid/code are a pure decode of the state flop so a withdrawn message drops at once.
  assign sb.tx_valid = (state == S_SEND_REQ) || (state == S_SEND_RESP);
  assign sb.tx_msg   = (state == S_SEND_REQ)  ? MSG_REQ  :
                       (state == S_SEND_RESP) ? MSG_RESP : 4'h0;
  assign sb.tx_data  = tx_data_q;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state               <= S_IDLE;
      l_rate              <= 3'd0;
      l_mode              <= 2'd0;
      l_phase             <= 2'd0;
      r_rate              <= 3'd0;
      r_mode              <= 2'd0;
      r_phase             <= 2'd0;
      req_pending         <= 1'b0;
      req_answered        <= 1'b0;
      resp_got            <= 1'b0;
      cnt                 <= '0;
      tx_data_q           <= 16'd0;
      o_Final_DataRate    <= 3'd0;
      o_Final_Clock_Mode  <= 2'd0;
      o_Final_Phase_Clock <= 2'd0;
      o_done              <= 1'b0;
      o_error             <= 1'b0;
    end else if (!i_en) begin
      state               <= S_IDLE;
      req_pending         <= 1'b0;
      req_answered        <= 1'b0;
      resp_got            <= 1'b0;
      cnt                 <= '0;
      tx_data_q           <= 16'd0;
      o_Final_DataRate    <= 3'd0;
      o_Final_Clock_Mode  <= 2'd0;
      o_Final_Phase_Clock <= 2'd0;
      o_done              <= 1'b0;
      o_error             <= 1'b0;
    end else if (state == S_IDLE) begin
      l_rate       <= i_Max_DataRate;
      l_mode       <= i_Clock_Mode;
      l_phase      <= i_Phase_Clock;
      req_pending  <= 1'b0;
      req_answered <= 1'b0;
      resp_got     <= 1'b0;
      cnt          <= '0;
      tx_data_q    <= {9'd0, i_Phase_Clock, i_Clock_Mode, i_Max_DataRate};
      state        <= S_SEND_REQ;
    end else if (active) begin
      cnt <= cnt + CNT_W'(1);

      // A REQ arriving on the RESP handshake edge re-arms req_pending (later NBA wins).
      if ((state == S_SEND_RESP) && hs) begin
        req_answered <= 1'b1;
        req_pending  <= 1'b0;
      end
      if (rx_req) begin
        r_rate      <= rx_rate;
        r_mode      <= rx_mode;
        r_phase     <= rx_phase;
        req_pending <= 1'b1;
      end
      if (rx_resp) begin
        o_Final_DataRate    <= rx_rate;
        o_Final_Clock_Mode  <= rx_mode;
        o_Final_Phase_Clock <= rx_phase;
        resp_got            <= 1'b1;
      end

      // Bad partner data beats everything; completion beats the timeout.
      if (req_bad || resp_bad) begin
        state     <= S_ERROR;
        o_error   <= 1'b1;
        tx_data_q <= 16'd0;
      end else if (done_cond) begin
        state  <= S_DONE;
        o_done <= 1'b1;
      end else if (timeout) begin
        state     <= S_ERROR;
        o_error   <= 1'b1;
        tx_data_q <= 16'd0;
      end else begin
        case (state)
          S_SEND_REQ: begin
            if (hs) begin
              state     <= S_WAIT;
              tx_data_q <= 16'd0;
            end
          end
          S_WAIT: begin
            if (req_pending) begin
              state     <= S_SEND_RESP;
              tx_data_q <= {9'd0, r_phase, r_mode, resp_rate};
            end
          end
          S_SEND_RESP: begin
            if (hs) begin
              state     <= S_WAIT;
              tx_data_q <= 16'd0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
